// File: rtl/matmul_sequencer.sv
// Sequencer for one sigma^T*J*sigma energy job on the MatMul datapath.
//
// A job carries sigma, the previous energy and the J base address. The
// sequencer locks the shared J memory port, then issues one chunk address per
// cycle. It pulses dp_start so that chunk k reaches the datapath in the
// datapath's k-th accumulate cycle. It then captures the final energy and
// returns it over a valid/ready handshake, together with an accept flag that
// is set when the energy went down.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*          job request (ready only while idle)
//   mem_req/gnt                     memory port lock handshake (gnt is a level)
//   mem_addr_valid, mem_addr        one strobe per chunk, base + chunk index
//   dp_start, dp_sigma,
//   dp_energy_prev, dp_energy       datapath control and running energy
//   res_valid/ready, res_energy,
//   res_accept                      result handshake
//   busy                            high in every state except idle
//   perf_jobs, perf_accepts         only when MATMUL_SEQ_PERF_CNT_EN is defined
//
// Optional feature: define MATMUL_SEQ_PERF_CNT_EN to add the two 32-bit
// performance counters.

module matmul_sequencer #(
  parameter int unsigned VECTOR_SIZE     = 256,
  parameter int unsigned J_ELEMENT_WIDTH = 4,
  parameter int unsigned MEM_BANDWIDTH   = 1024,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned MEM_LATENCY     = 2,
  localparam int unsigned J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
  localparam int unsigned NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
  localparam int unsigned ENERGY_WIDTH    = 2 * $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [VECTOR_SIZE-1:0]  cmd_sigma,
  input  logic [ENERGY_WIDTH-1:0] cmd_energy_prev,
  input  logic [ADDR_WIDTH-1:0]   cmd_base_addr,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic                    mem_addr_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    dp_start,
  output logic [VECTOR_SIZE-1:0]  dp_sigma,
  output logic [ENERGY_WIDTH-1:0] dp_energy_prev,
  input  logic [ENERGY_WIDTH-1:0] dp_energy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ENERGY_WIDTH-1:0] res_energy,
  output logic                    res_accept,
`ifdef MATMUL_SEQ_PERF_CNT_EN
  output logic [31:0]             perf_jobs,
  output logic [31:0]             perf_accepts,
`endif
  output logic                    busy
);

  // One tick counter runs from the first address cycle (tick 0) to capture.
  localparam int unsigned LastIssue = NUM_J_CHUNKS - 1;
  localparam int unsigned StartTick = MEM_LATENCY - 1;
  // Datapath accumulates at StartTick+1 .. StartTick+NUM_J_CHUNKS; sample one later.
  localparam int unsigned CapTick   = StartTick + NUM_J_CHUNKS + 1;
  localparam int unsigned TickW     = $clog2(CapTick + 1) + 1;

  typedef enum logic [2:0] {StIdle, StLock, StIssue, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [TickW-1:0]        tick_q, tick_d;
  logic [VECTOR_SIZE-1:0]  sigma_q;
  logic [ENERGY_WIDTH-1:0] energy_prev_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ENERGY_WIDTH-1:0] res_energy_q;
  logic                    res_accept_q;
  logic                    capture;

  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    cmd_ready      = 1'b0;
    mem_req        = 1'b0;
    mem_addr_valid = 1'b0;
    mem_addr       = '0;
    dp_start       = 1'b0;
    res_valid      = 1'b0;
    capture        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = StLock;
      end
      StLock: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_d = StIssue;
          tick_d  = '0;
        end
      end
      StIssue: begin
        // mem_gnt is deliberately not looked at here: a drop is ignored.
        mem_req        = 1'b1;
        mem_addr_valid = 1'b1;
        mem_addr       = base_q + ADDR_WIDTH'(tick_q);
        tick_d         = tick_q + 1'b1;
        if (tick_q == TickW'(LastIssue)) state_d = StWait;
      end
      StWait: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TickW'(CapTick)) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The start pulse can land in either issue or wait, depending on latency.
    if ((state_q == StIssue || state_q == StWait) && tick_q == TickW'(StartTick)) begin
      dp_start = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tick_q        <= '0;
      sigma_q       <= '0;
      energy_prev_q <= '0;
      base_q        <= '0;
      res_energy_q  <= '0;
      res_accept_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      if (cmd_valid && cmd_ready) begin
        sigma_q       <= cmd_sigma;
        energy_prev_q <= cmd_energy_prev;
        base_q        <= cmd_base_addr;
      end
      if (capture) begin
        res_energy_q <= dp_energy;
        res_accept_q <= $signed(dp_energy) < $signed(energy_prev_q);
      end
    end
  end

`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [31:0] perf_jobs_q, perf_accepts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs_q    <= '0;
      perf_accepts_q <= '0;
    end else if (res_valid && res_ready) begin
      perf_jobs_q <= perf_jobs_q + 32'd1;
      if (res_accept_q) perf_accepts_q <= perf_accepts_q + 32'd1;
    end
  end

  assign perf_jobs    = perf_jobs_q;
  assign perf_accepts = perf_accepts_q;
`endif

  assign busy           = (state_q != StIdle);
  assign dp_sigma       = sigma_q;
  assign dp_energy_prev = energy_prev_q;
  assign res_energy     = res_energy_q;
  assign res_accept     = res_accept_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: 8-element sigma, 4 chunks, latency 2.
module tb_matmul_sequencer;

  localparam int unsigned VS = 8;
  localparam int unsigned EW = 2 * $clog2(VS) + 4 + 1;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [VS-1:0] cmd_sigma;
  logic [EW-1:0] cmd_energy_prev;
  logic [AW-1:0] cmd_base_addr;
  logic          mem_req, mem_gnt, mem_addr_valid;
  logic [AW-1:0] mem_addr;
  logic          dp_start;
  logic [VS-1:0] dp_sigma;
  logic [EW-1:0] dp_energy_prev, dp_energy;
  logic          res_valid, res_ready, res_accept, busy;
  logic [EW-1:0] res_energy;
`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [31:0]   perf_jobs, perf_accepts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matmul_sequencer #(
    .VECTOR_SIZE    (VS),
    .J_ELEMENT_WIDTH(4),
    .MEM_BANDWIDTH  (64),
    .ADDR_WIDTH     (AW),
    .MEM_LATENCY    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_sigma      (cmd_sigma),
    .cmd_energy_prev(cmd_energy_prev),
    .cmd_base_addr  (cmd_base_addr),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr       (mem_addr),
    .dp_start       (dp_start),
    .dp_sigma       (dp_sigma),
    .dp_energy_prev (dp_energy_prev),
    .dp_energy      (dp_energy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_energy     (res_energy),
    .res_accept     (res_accept),
`ifdef MATMUL_SEQ_PERF_CNT_EN
    .perf_jobs      (perf_jobs),
    .perf_accepts   (perf_accepts),
`endif
    .busy           (busy)
  );

  // Datapath stand-in: clears on dp_start, adds -3 on each of the next four
  // cycles (ending at -12), holds for one cycle, then self-clears.
  logic [EW-1:0] acc;
  logic [2:0]    act;
  assign dp_energy = acc;

  always @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      act <= '0;
    end else if (dp_start) begin
      acc <= '0;
      act <= 3'd5;
    end else if (act != 3'd0) begin
      act <= act - 3'd1;
      acc <= (act == 3'd1) ? '0 : acc - EW'(3);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full job from an idle negedge back to an idle negedge.
  task automatic run_job(input logic [AW-1:0] base, input logic [VS-1:0] sig, input int prev,
                         input int gnt_dly, input int rdy_dly, input bit drop_gnt,
                         input bit exp_acc);
    logic [EW-1:0] exp_e;
    logic [EW-1:0] exp_prev;
    logic [AW-1:0] exp_a;
    exp_e    = EW'(-12);
    exp_prev = EW'(prev);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    cmd_valid       = 1'b1;
    cmd_sigma       = sig;
    cmd_energy_prev = exp_prev;
    cmd_base_addr   = base;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_sigma = ~sig;
    cmd_base_addr = 16'h5555;
    for (int i = 0; i <= gnt_dly; i++) begin
      check("lock_req", mem_req, 1);
      check("lock_no_addr", mem_addr_valid, 0);
      check("lock_ready", cmd_ready, 0);
      mem_gnt = (i == gnt_dly);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      exp_a = base + AW'(k);
      check("issue_valid", mem_addr_valid, 1);
      check("issue_addr", mem_addr, exp_a);
      check("issue_start", dp_start, (k == 1) ? 1 : 0);
      check("issue_sigma", dp_sigma, sig);
      if (drop_gnt) mem_gnt = 1'b0;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    for (int t = 0; t < 3; t++) begin
      check("wait_req", mem_req, 0);
      check("wait_no_addr", mem_addr_valid, 0);
      check("wait_no_start", dp_start, 0);
      check("wait_no_res", res_valid, 0);
      @(negedge clk);
    end
    check("res_valid", res_valid, 1);
    check("res_energy", res_energy, exp_e);
    check("res_accept", res_accept, exp_acc);
    check("res_prev", dp_energy_prev, exp_prev);
    // Consumer stalls while a new command is already waiting.
    cmd_valid = 1'b1;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_energy", res_energy, exp_e);
      check("hold_accept", res_accept, exp_acc);
      check("hold_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_ready", cmd_ready, 1);
    check("post_res", res_valid, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_sigma = '0; cmd_energy_prev = '0;
    cmd_base_addr = '0; mem_gnt = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_res", res_valid, 0);
    check("rst_sigma", dp_sigma, 0);

    run_job(16'h0010, 8'hA5, -5, 0, 0, 1'b0, 1'b1);
    run_job(16'h0010, 8'h3C, -12, 7, 0, 1'b0, 1'b0);
    run_job(16'hFFFE, 8'h81, 0, 2, 10, 1'b1, 1'b1);

`ifdef MATMUL_SEQ_PERF_CNT_EN
    check("perf_jobs", perf_jobs, 3);
    check("perf_accepts", perf_accepts, 2);
`endif

    // Reset in the middle of issue, with chunk 2 on the bus.
    cmd_valid = 1'b1; cmd_sigma = 8'h0F; cmd_base_addr = 16'h0020; cmd_energy_prev = '0;
    @(negedge clk);
    cmd_valid = 1'b0; mem_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_addr", mem_addr, 16'h0022);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_gnt = 1'b0;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_addr", mem_addr_valid, 0);
    check("mid_rst_sigma", dp_sigma, 0);
`ifdef MATMUL_SEQ_PERF_CNT_EN
    check("perf_clr", perf_jobs, 0);
`endif
    repeat (6) @(negedge clk);
    check("mid_rst_idle", busy, 0);
    check("mid_rst_nores", res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
